axi_read_arbiter: RTL and testbench

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter.sv | 128 ++++++++++++
 tb/tb_axi_read_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// AXI read arbiter: shares one AXI AR/R channel between the instruction
// and data caches with round-robin grant and one read outstanding.
module axi_read_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,

    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,

    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [3:0]  m_arid,
    output logic        m_arvalid,
    input  logic        m_arready,

    input  logic [31:0] m_rdata,
    input  logic [3:0]  m_rid,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,

    output logic        rd_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    logic        gnt_d;
    logic        last_d;
    logic [31:0] lat_addr;
    logic [7:0]  lat_len;
    logic [7:0]  beat_cnt;

    logic        win_d;
    logic        in_addr;
    logic        in_data;
    logic        beat_fire;
    logic [3:0]  issued_id;
    logic        id_bad;
    logic        last_early;
    logic        last_missing;

    // On a tie the side that did not win last time gets the bus.
    assign win_d = d_arvalid && (!i_arvalid || !last_d);

    assign in_addr   = (state == ADDR);
    assign in_data   = (state == DATA);
    assign issued_id = {3'b000, gnt_d};

    assign m_arvalid = in_addr;
    assign m_araddr  = lat_addr;
    assign m_arlen   = lat_len;
    assign m_arid    = issued_id;

    assign i_arready = in_addr && !gnt_d && m_arready;
    assign d_arready = in_addr && gnt_d && m_arready;

    assign m_rready = in_data && (gnt_d ? d_rready : i_rready);

    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign i_rvalid = in_data && !gnt_d && m_rvalid;
    assign d_rvalid = in_data && gnt_d && m_rvalid;
    assign i_rlast  = in_data && !gnt_d && m_rlast;
    assign d_rlast  = in_data && gnt_d && m_rlast;

    assign beat_fire    = in_data && m_rvalid && m_rready;
    assign id_bad       = (m_rid != issued_id);
    assign last_early   = m_rlast && (beat_cnt != lat_len);
    assign last_missing = !m_rlast && (beat_cnt == lat_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt_d    <= 1'b0;
            last_d   <= 1'b0;
            lat_addr <= 32'd0;
            lat_len  <= 8'd0;
            beat_cnt <= 8'd0;
            rd_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_arvalid || d_arvalid) begin
                        gnt_d    <= win_d;
                        lat_addr <= win_d ? d_araddr : i_araddr;
                        lat_len  <= win_d ? d_arlen : i_arlen;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        beat_cnt <= 8'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (id_bad || last_early || last_missing)
                            rd_err <= 1'b1;
                        if (m_rlast) begin
                            last_d <= gnt_d;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: the bench plays the AXI slave and both
// caches; forwarded beats are checked against a scoreboard queue.
module tb_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        i_rvalid;
    logic        i_rready;
    logic [31:0] d_araddr;
    logic [7:0]  d_arlen;
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic        d_rvalid;
    logic        d_rready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [3:0]  m_arid;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [3:0]  m_rid;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic        rd_err;

    int n_vec = 0;
    int n_bad = 0;
    bit err_exp = 0;
    logic [33:0] sb[$];

    axi_read_arbiter dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast),
        .d_rvalid(d_rvalid), .d_rready(d_rready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rready(input bit d, input logic v);
        if (d) d_rready = v;
        else i_rready = v;
    endtask

    // Caller has raised arvalid in an IDLE cycle.
    task automatic ar_phase(input bit d, input logic [31:0] a,
                            input logic [7:0] l);
        @(negedge clk);
        chk("idle_arvalid", m_arvalid, 0);
        step();
        if (d) begin
            d_arvalid = 0; d_araddr = ~a; d_arlen = ~l;
        end else begin
            i_arvalid = 0; i_araddr = ~a; i_arlen = ~l;
        end
        m_arready = 0;
        @(negedge clk);
        chk("ar_valid", m_arvalid, 1);
        chk("ar_addr", m_araddr, a);
        chk("ar_len", m_arlen, l);
        chk("ar_id", m_arid, {3'b000, d});
        chk("ar_rdy_hold", {i_arready, d_arready}, 0);
        step();
        m_arready = 1;
        @(negedge clk);
        chk("ar_rdy_win", d ? d_arready : i_arready, 1);
        chk("ar_rdy_lose", d ? i_arready : d_arready, 0);
        step();
        m_arready = 0;
    endtask

    task automatic r_phase(input bit d, input logic [7:0] l, input int nb,
                           input logic [3:0] rid, input int stall,
                           input logic [31:0] base);
        for (int b = 0; b < nb; b++) begin
            m_rvalid = 1;
            m_rdata  = base + b;
            m_rlast  = (b == nb - 1);
            m_rid    = rid;
            if (b == 1) begin
                for (int s = 0; s < stall; s++) begin
                    set_rready(d, 0);
                    @(negedge clk);
                    chk("stall_mrready", m_rready, 0);
                    chk("stall_rvalid", d ? d_rvalid : i_rvalid, 1);
                    step();
                end
            end
            set_rready(d, 1);
            sb.push_back({d, m_rlast, m_rdata});
            if (rid != {3'b000, d} || (m_rlast && b != int'(l)) ||
                (!m_rlast && b == int'(l)))
                err_exp = 1;
            @(negedge clk);
            chk("beat_mrready", m_rready, 1);
            chk("beat_other", d ? i_rvalid : d_rvalid, 0);
            step();
        end
        m_rvalid = 0;
        m_rlast  = 0;
        #1;
        chk("done_idle", {m_arvalid, m_rready}, 0);
        chk("rd_err", rd_err, err_exp);
    endtask

    always @(negedge clk) begin
        logic [33:0] got;
        chk("one_side", i_rvalid && d_rvalid, 0);
        if ((i_rvalid && i_rready) || (d_rvalid && d_rready)) begin
            got = d_rvalid ? {1'b1, d_rlast, d_rdata}
                           : {1'b0, i_rlast, i_rdata};
            if (sb.size() == 0) chk("sb_extra", sb.size(), 1);
            else chk("beat", got, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        i_araddr = 0; i_arlen = 0; i_arvalid = 0; i_rready = 0;
        d_araddr = 0; d_arlen = 0; d_arvalid = 0; d_rready = 0;
        m_arready = 0; m_rdata = 0; m_rid = 0; m_rlast = 0; m_rvalid = 0;
        #3;
        chk("rst_m", {m_arvalid, m_rready, m_araddr, m_arid}, 0);
        chk("rst_x", {i_arready, d_arready, i_rvalid, d_rvalid,
                      i_rlast, d_rlast, rd_err}, 0);
        step();
        step();
        rst = 1;

        // Tie in the first IDLE: D wins, I follows.
        i_arvalid = 1; i_araddr = 32'h0000_1000; i_arlen = 0;
        d_arvalid = 1; d_araddr = 32'h8000_0040; d_arlen = 1;
        ar_phase(1, 32'h8000_0040, 8'd1);
        r_phase(1, 8'd1, 2, 4'd1, 0, 32'hD000_0000);
        ar_phase(0, 32'h0000_1000, 8'd0);
        r_phase(0, 8'd0, 1, 4'd0, 0, 32'h1100_0000);

        i_arvalid = 1; i_araddr = 32'h1FC0_0000; i_arlen = 0;
        ar_phase(0, 32'h1FC0_0000, 8'd0);
        r_phase(0, 8'd0, 1, 4'd0, 0, 32'h2408_0001);

        d_arvalid = 1; d_araddr = 32'h8000_1000; d_arlen = 3;
        ar_phase(1, 32'h8000_1000, 8'd3);
        r_phase(1, 8'd3, 4, 4'd1, 2, 32'hA000_0000);

        // Stray beat while IDLE.
        m_rvalid = 1; m_rlast = 1; m_rid = 4'd5; m_rdata = 32'hBAD0_0000;
        i_rready = 1; d_rready = 1;
        @(negedge clk);
        chk("stray_mrready", m_rready, 0);
        chk("stray_rvalid", {i_rvalid, d_rvalid}, 0);
        step();
        m_rvalid = 0; m_rlast = 0;
        #1;
        chk("stray_err", rd_err, err_exp);

        d_arvalid = 1; d_araddr = 32'h8000_2000; d_arlen = 0;
        ar_phase(1, 32'h8000_2000, 8'd0);
        r_phase(1, 8'd0, 1, 4'd2, 0, 32'hB000_0000);

        i_arvalid = 1; i_araddr = 32'h1FC0_0010; i_arlen = 1;
        ar_phase(0, 32'h1FC0_0010, 8'd1);
        r_phase(0, 8'd1, 2, 4'd0, 0, 32'hC000_0000);

        // Reset in the middle of DATA.
        i_arvalid = 1; i_araddr = 32'h1FC0_0020; i_arlen = 0;
        ar_phase(0, 32'h1FC0_0020, 8'd0);
        m_rvalid = 1; m_rlast = 1; m_rid = 0; m_rdata = 32'hEEEE_0000;
        i_rready = 0;
        #1;
        chk("pre_rst_rvalid", i_rvalid, 1);
        #1;
        rst = 0;
        #1;
        chk("mid_rst_m", {m_arvalid, m_rready, m_araddr, m_arid}, 0);
        chk("mid_rst_x", {i_arready, d_arready, i_rvalid, d_rvalid,
                          i_rlast, d_rlast, rd_err}, 0);
        i_rready = 1;
        @(negedge clk);
        chk("rst_no_beat", {i_rvalid, m_rready}, 0);
        step();
        rst = 1;
        m_rvalid = 0; m_rlast = 0;
        err_exp = 0;

        i_arvalid = 1; i_araddr = 32'h1FC0_0000; i_arlen = 0;
        ar_phase(0, 32'h1FC0_0000, 8'd0);
        r_phase(0, 8'd0, 1, 4'd0, 0, 32'h2408_0001);

        d_arvalid = 1; d_araddr = 32'h8000_3000; d_arlen = 3;
        ar_phase(1, 32'h8000_3000, 8'd3);
        r_phase(1, 8'd3, 3, 4'd1, 0, 32'hF000_0000);

        i_arvalid = 1; i_araddr = 32'h1FC0_0040; i_arlen = 0;
        ar_phase(0, 32'h1FC0_0040, 8'd0);
        r_phase(0, 8'd0, 1, 4'd0, 0, 32'h1234_5678);

        step();
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
